// File: rtl/lc_arbiter_rr.sv
// rtl/lc_arbiter_rr.sv - round-robin arbiter sharing one 9x9 cell line/col lookup; option macro RANGE_CHECK_EN
module lc_table_9_9 #(
    parameter int CELL_W = 7,
    parameter int LC_W   = 8
) (
    input  logic [CELL_W-1:0] c1,
    input  logic [CELL_W-1:0] c2,
    output logic [LC_W-1:0]   lc1,
    output logic [LC_W-1:0]   lc2
);
    // Row-major 9x9 grid: line = cell / 9, col = cell % 9.
    function automatic logic [LC_W-1:0] lookup(input logic [CELL_W-1:0] c);
        logic [CELL_W-1:0] line;
        logic [CELL_W-1:0] col;
        line = c / CELL_W'(9);
        col  = c % CELL_W'(9);
        return LC_W'({line[3:0], col[3:0]});
    endfunction

    assign lc1 = lookup(c1);
    assign lc2 = lookup(c2);
endmodule

module lc_arbiter_rr #(
    parameter int N_REQ  = 4,
    parameter int ID_W   = 2,
    parameter int CELL_W = 7,
    parameter int LC_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*CELL_W-1:0]   req_c1,
    input  logic [N_REQ*CELL_W-1:0]   req_c2,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [ID_W-1:0]           resp_id,
    output logic [LC_W-1:0]           resp_lc1,
    output logic [LC_W-1:0]           resp_lc2,
    output logic                      resp_err
);
    localparam logic [ID_W-1:0] PTR_RST = ID_W'(N_REQ - 1);

    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   lo_idx;
    logic [ID_W-1:0]   hi_idx;
    logic [ID_W-1:0]   sel;
    logic              lo_hit;
    logic              hi_hit;
    logic              slot_free;
    logic              xfer;
    logic [CELL_W-1:0] sel_c1;
    logic [CELL_W-1:0] sel_c2;
    logic [LC_W-1:0]   tab_lc1;
    logic [LC_W-1:0]   tab_lc2;
    logic [LC_W-1:0]   nxt_lc1;
    logic [LC_W-1:0]   nxt_lc2;

    assign slot_free = !resp_valid || resp_ready;

    // Cyclic search from ptr+1: prefer the lowest valid index above ptr,
    // otherwise wrap to the lowest valid index overall (which may be ptr).
    always_comb begin
        lo_idx = '0;
        hi_idx = '0;
        lo_hit = 1'b0;
        hi_hit = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_idx = ID_W'(i);
                lo_hit = 1'b1;
            end
            if (req_valid[i] && (i > int'(ptr))) begin
                hi_idx = ID_W'(i);
                hi_hit = 1'b1;
            end
        end
        sel = hi_hit ? hi_idx : lo_idx;
    end

    assign xfer      = lo_hit && slot_free && rst_n;
    assign req_ready = xfer ? (N_REQ'(1) << sel) : '0;

    always_comb begin
        sel_c1 = '0;
        sel_c2 = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == sel) begin
                sel_c1 = req_c1[i*CELL_W +: CELL_W];
                sel_c2 = req_c2[i*CELL_W +: CELL_W];
            end
        end
    end

    lc_table_9_9 #(
        .CELL_W (CELL_W),
        .LC_W   (LC_W)
    ) u_table (
        .c1  (sel_c1),
        .c2  (sel_c2),
        .lc1 (tab_lc1),
        .lc2 (tab_lc2)
    );

`ifdef RANGE_CHECK_EN
    logic bad1;
    logic bad2;
    assign bad1    = sel_c1 >= CELL_W'(81);
    assign bad2    = sel_c2 >= CELL_W'(81);
    assign nxt_lc1 = bad1 ? '1 : tab_lc1;
    assign nxt_lc2 = bad2 ? '1 : tab_lc2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_err <= 1'b0;
        end else if (xfer) begin
            resp_err <= bad1 || bad2;
        end
    end
`else
    assign nxt_lc1  = tab_lc1;
    assign nxt_lc2  = tab_lc2;
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr        <= PTR_RST;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_lc1   <= '0;
            resp_lc2   <= '0;
        end else if (xfer) begin
            ptr        <= sel;
            resp_valid <= 1'b1;
            resp_id    <= sel;
            resp_lc1   <= nxt_lc1;
            resp_lc2   <= nxt_lc2;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_lc_arbiter_rr.sv
// tb/tb_lc_arbiter_rr.sv - scoreboard bench for lc_arbiter_rr
module tb_lc_arbiter_rr;
    localparam int N = 4;
    localparam int CW = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [N*CW-1:0] req_c1;
    logic [N*CW-1:0] req_c2;
    logic [N-1:0]  req_ready;
    logic          resp_valid;
    logic          resp_ready;
    logic [1:0]    resp_id;
    logic [7:0]    resp_lc1;
    logic [7:0]    resp_lc2;
    logic          resp_err;

    logic [CW-1:0] c1_arr [N];
    logic [CW-1:0] c2_arr [N];

    typedef struct {
        logic [1:0] id;
        logic [7:0] lc1;
        logic [7:0] lc2;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   chk_en = 1'b0;
    int   m_ptr = N - 1;
    bit   m_valid = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_c1[i*CW +: CW] = c1_arr[i];
            req_c2[i*CW +: CW] = c2_arr[i];
        end
    end

    lc_arbiter_rr #(.N_REQ(4), .ID_W(2), .CELL_W(7), .LC_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_c1     (req_c1),
        .req_c2     (req_c2),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_lc1   (resp_lc1),
        .resp_lc2   (resp_lc2),
        .resp_err   (resp_err)
    );

    function automatic logic [7:0] exp_lc(input logic [CW-1:0] c);
        int v;
        v = int'(c);
`ifdef RANGE_CHECK_EN
        if (v >= 81) return 8'hFF;
`endif
        return {4'(v / 9), 4'(v % 9)};
    endfunction

    function automatic logic exp_err(input logic [CW-1:0] a, input logic [CW-1:0] b);
`ifdef RANGE_CHECK_EN
        return (int'(a) >= 81) || (int'(b) >= 81);
`else
        return (a === 7'h7F) && (b === 7'h7F) && 1'b0;
`endif
    endfunction

    // Reference model + scoreboard: expectations pushed at grant, popped on drain.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [N-1:0] exp_g;
            int           g;
            bit           hit;
            exp_t         e;
            n_vec++;
            if (resp_valid !== m_valid) begin
                n_err++;
                $display("FAIL sb_resp_valid: got %b want %b", resp_valid, m_valid);
            end
            if (resp_valid === 1'b1 && sb.size() > 0) begin
                e = sb[0];
                n_vec++;
                if ({resp_id, resp_lc1, resp_lc2, resp_err} !== {e.id, e.lc1, e.lc2, e.err}) begin
                    n_err++;
                    $display("FAIL sb_resp: got id=%0d lc1=%h lc2=%h err=%b want id=%0d lc1=%h lc2=%h err=%b",
                             resp_id, resp_lc1, resp_lc2, resp_err, e.id, e.lc1, e.lc2, e.err);
                end
                if (resp_ready === 1'b1) void'(sb.pop_front());
            end
            exp_g = '0;
            hit = 1'b0;
            g = 0;
            if (rst_n && (!m_valid || resp_ready)) begin
                for (int k = 1; k <= N; k++) begin
                    int j;
                    j = (m_ptr + k) % N;
                    if (!hit && req_valid[j]) begin
                        hit = 1'b1;
                        g = j;
                    end
                end
                if (hit) exp_g = N'(1) << g;
            end
            n_vec++;
            if (req_ready !== exp_g) begin
                n_err++;
                $display("FAIL sb_req_ready: got %b want %b", req_ready, exp_g);
            end
            if (!rst_n) begin
                m_ptr = N - 1;
                m_valid = 1'b0;
                sb.delete();
            end else if (hit) begin
                e.id  = 2'(g);
                e.lc1 = exp_lc(c1_arr[g]);
                e.lc2 = exp_lc(c2_arr[g]);
                e.err = exp_err(c1_arr[g], c2_arr[g]);
                sb.push_back(e);
                m_ptr = g;
                m_valid = 1'b1;
            end else if (resp_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '1;
        resp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            c1_arr[i] = 7'(i + 1);
            c2_arr[i] = 7'(i + 2);
        end
        cyc();
        chk_en = 1'b1;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            n_vec++;
            if (req_ready !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_req_ready: got %b want 0000", req_ready);
            end
            n_vec++;
            if ({resp_valid, resp_id, resp_lc1, resp_lc2, resp_err} !== 20'h0) begin
                n_err++;
                $display("FAIL reset_resp: got v=%b id=%0d lc1=%h lc2=%h err=%b want all 0",
                         resp_valid, resp_id, resp_lc1, resp_lc2, resp_err);
            end
            if (n == 0) cyc();
        end
    endtask

    task automatic test_single();
        cyc();
        rst_n = 1'b1;
        req_valid = 4'b0100;
        c1_arr[2] = 7'd40;
        c2_arr[2] = 7'd80;
        resp_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 4'b0100) begin
            n_err++;
            $display("FAIL single_grant: got %b want 0100", req_ready);
        end
        cyc();
        req_valid = '0;
        @(negedge clk);
        n_vec++;
        if ({resp_valid, resp_id, resp_lc1, resp_lc2} !== {1'b1, 2'd2, 8'h44, 8'h88}) begin
            n_err++;
            $display("FAIL single_resp: got v=%b id=%0d lc1=%h lc2=%h want v=1 id=2 lc1=44 lc2=88",
                     resp_valid, resp_id, resp_lc1, resp_lc2);
        end
        cyc();
    endtask

    task automatic test_round_robin();
        int exp_seq [6] = '{0, 1, 2, 3, 0, 1};
        cyc();
        rst_n = 1'b0;
        req_valid = '0;
        cyc();
        rst_n = 1'b1;
        resp_ready = 1'b1;
        req_valid = '1;
        for (int i = 0; i < N; i++) begin
            c1_arr[i] = 7'(i * 20);
            c2_arr[i] = 7'(i * 20 + 3);
        end
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            n_vec++;
            if (req_ready !== (4'b0001 << exp_seq[n])) begin
                n_err++;
                $display("FAIL rr_grant[%0d]: got %b want %b", n, req_ready, 4'b0001 << exp_seq[n]);
            end
            if (n > 0) begin
                n_vec++;
                if (resp_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL rr_resp_valid[%0d]: got %b want 1", n, resp_valid);
                end
            end
            cyc();
        end
        req_valid = '0;
    endtask

    task automatic test_back_pressure();
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        req_valid = 4'b0010;
        c1_arr[1] = 7'd10;
        c2_arr[1] = 7'd9;
        resp_ready = 1'b0;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL bp_first_grant: got %b want 0010", req_ready);
        end
        cyc();
        req_valid = '1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            n_vec++;
            if (req_ready !== 4'b0000) begin
                n_err++;
                $display("FAIL bp_ready[%0d]: got %b want 0000", n, req_ready);
            end
            n_vec++;
            if ({resp_valid, resp_id, resp_lc1, resp_lc2} !== {1'b1, 2'd1, 8'h11, 8'h10}) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got v=%b id=%0d lc1=%h lc2=%h want v=1 id=1 lc1=11 lc2=10",
                         n, resp_valid, resp_id, resp_lc1, resp_lc2);
            end
            if (n < 2) cyc();
        end
        cyc();
        resp_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 4'b0100) begin
            n_err++;
            $display("FAIL bp_release_grant: got %b want 0100", req_ready);
        end
        cyc();
        req_valid = '0;
        cyc();
    endtask

    task automatic test_range();
        logic [7:0] e1a, e2a, e1b, e2b;
        logic       era;
`ifdef RANGE_CHECK_EN
        c1_arr[0] = 7'd81;
        c2_arr[0] = 7'd0;
        e1a = 8'hFF; e2a = 8'h00; era = 1'b1;
`else
        c1_arr[0] = 7'd0;
        c2_arr[0] = 7'd80;
        e1a = 8'h00; e2a = 8'h88; era = 1'b0;
`endif
        e1b = 8'h05; e2b = 8'h06;
        resp_ready = 1'b1;
        req_valid = 4'b0001;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL range_grant: got %b want 0001", req_ready);
        end
        cyc();
        c1_arr[0] = 7'd5;
        c2_arr[0] = 7'd6;
        @(negedge clk);
        n_vec++;
        if ({resp_id, resp_lc1, resp_lc2, resp_err} !== {2'd0, e1a, e2a, era}) begin
            n_err++;
            $display("FAIL range_edge: got id=%0d lc1=%h lc2=%h err=%b want id=0 lc1=%h lc2=%h err=%b",
                     resp_id, resp_lc1, resp_lc2, resp_err, e1a, e2a, era);
        end
        cyc();
        req_valid = '0;
        @(negedge clk);
        n_vec++;
        if ({resp_valid, resp_lc1, resp_lc2, resp_err} !== {1'b1, e1b, e2b, 1'b0}) begin
            n_err++;
            $display("FAIL range_next: got v=%b lc1=%h lc2=%h err=%b want v=1 lc1=%h lc2=%h err=0",
                     resp_valid, resp_lc1, resp_lc2, resp_err, e1b, e2b);
        end
    endtask

    task automatic test_reset_mid();
        cyc();
        req_valid = 4'b0100;
        c1_arr[2] = 7'd1;
        c2_arr[2] = 7'd2;
        resp_ready = 1'b0;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 4'b0100) begin
            n_err++;
            $display("FAIL mid_grant: got %b want 0100", req_ready);
        end
        cyc();
        req_valid = 4'b1001;
        rst_n = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({resp_valid, req_ready} !== {1'b1, 4'b0000}) begin
            n_err++;
            $display("FAIL mid_in_reset: got v=%b ready=%b want v=1 ready=0000", resp_valid, req_ready);
        end
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({resp_valid, req_ready} !== {1'b0, 4'b0001}) begin
            n_err++;
            $display("FAIL mid_after_reset: got v=%b ready=%b want v=0 ready=0001", resp_valid, req_ready);
        end
        cyc();
        req_valid = '0;
        @(negedge clk);
        n_vec++;
        if ({resp_valid, resp_id} !== {1'b1, 2'd0}) begin
            n_err++;
            $display("FAIL mid_resp: got v=%b id=%0d want v=1 id=0", resp_valid, resp_id);
        end
        cyc();
        resp_ready = 1'b1;
        cyc();
        cyc();
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        resp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            c1_arr[i] = '0;
            c2_arr[i] = '0;
        end
        test_reset();
        test_single();
        test_round_robin();
        test_back_pressure();
        test_range();
        test_reset_mid();
        @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
